// File: rtl/sr_alignment_detector_if.sv
// Bus between the SR alignment detector and its driver: update strobe, the two
// OMEGA_DT inputs, and the detector status.
interface sr_alignment_detector_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 16
);
  logic                    clk_en;
  logic                    enable;
  logic signed [WIDTH-1:0] omega_dt_sr;
  logic signed [WIDTH-1:0] omega_dt_int;
  logic                    aligned;
  logic                    ignition_pulse;
  logic [WIDTH-1:0]        delta_abs;
  logic [1:0]              state;
  logic [CNT_W-1:0]        dwell_count;
  logic [CNT_W-1:0]        ignition_count;

  modport master (
    output clk_en, enable, omega_dt_sr, omega_dt_int,
    input  aligned, ignition_pulse, delta_abs, state, dwell_count, ignition_count
  );

  modport slave (
    input  clk_en, enable, omega_dt_sr, omega_dt_int,
    output aligned, ignition_pulse, delta_abs, state, dwell_count, ignition_count
  );
endinterface

// File: rtl/sr_alignment_detector.sv
// Declares alignment between the drifting SR f0 and an internal oscillator once
// |delta| stays in band for a dwell time; fires one ignition pulse per onset.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for an in-band delta with enable high
// CANDIDATE | in band, counting dwell ticks towards ALIGNED
// ALIGNED   | aligned asserted; held while |delta| <= TOL_EXIT
// COOLDOWN  | refractory period, ignores enable and delta
module sr_alignment_detector #(
  parameter int WIDTH     = 18,
  parameter int CNT_W     = 16,
  parameter int TOL_ENTER = 4,
  parameter int TOL_EXIT  = 8,
  parameter int DWELL     = 400,
  parameter int COOLDOWN  = 2000
) (
  input logic                   clk,
  input logic                   rst,
  sr_alignment_detector_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAND    = 2'd1,
    S_ALIGNED = 2'd2,
    S_COOL    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_FULL = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN - 1);
  localparam logic [WIDTH-1:0] TOL_IN     = WIDTH'(TOL_ENTER);
  localparam logic [WIDTH-1:0] TOL_OUT    = WIDTH'(TOL_EXIT);

  state_t st, st_nx;
  logic [CNT_W-1:0] dwell_q, dwell_nx;
  logic [CNT_W-1:0] cool_q, cool_nx;
  logic [CNT_W-1:0] ign_q, ign_nx, ign_inc;
  logic             pulse_q, pulse_nx;
  logic             aligned_q;
  logic [WIDTH-1:0] delta_q, delta_mag;
  logic             delta_vld;
  logic             in_enter, in_hold;
  logic signed [WIDTH:0] diff;

  // The difference of two WIDTH-bit signed values always has |diff| < 2^WIDTH,
  // so the low WIDTH bits of the two's-complement negation are exact.
  assign diff      = {bus.omega_dt_sr[WIDTH-1], bus.omega_dt_sr}
                   - {bus.omega_dt_int[WIDTH-1], bus.omega_dt_int};
  assign delta_mag = (diff[WIDTH-1:0] ^ {WIDTH{diff[WIDTH]}}) + WIDTH'(diff[WIDTH]);

  // delta_vld keeps the reset value of delta_q from looking like an in-band sample.
  assign in_enter = delta_vld && (delta_q <= TOL_IN);
  assign in_hold  = delta_vld && (delta_q <= TOL_OUT);
  assign ign_inc  = (&ign_q) ? ign_q : ign_q + 1'b1;

  always_comb begin
    st_nx    = st;
    dwell_nx = dwell_q;
    cool_nx  = cool_q;
    ign_nx   = ign_q;
    pulse_nx = 1'b0;
    case (st)
      S_IDLE: begin
        dwell_nx = '0;
        if (bus.enable && in_enter) begin
          if (DWELL == 1) begin
            st_nx    = S_ALIGNED;
            dwell_nx = DWELL_FULL;
            pulse_nx = 1'b1;
            ign_nx   = ign_inc;
          end else begin
            st_nx    = S_CAND;
            dwell_nx = CNT_W'(1);
          end
        end
      end
      S_CAND: begin
        if (!bus.enable || !in_enter) begin
          st_nx    = S_IDLE;
          dwell_nx = '0;
        end else if (dwell_q == DWELL_LAST) begin
          st_nx    = S_ALIGNED;
          dwell_nx = DWELL_FULL;
          pulse_nx = 1'b1;
          ign_nx   = ign_inc;
        end else begin
          dwell_nx = dwell_q + 1'b1;
        end
      end
      S_ALIGNED: begin
        if (!bus.enable || !in_hold) begin
          st_nx    = S_COOL;
          cool_nx  = '0;
          dwell_nx = '0;
        end
      end
      S_COOL: begin
        if (cool_q == COOL_LAST) begin
          st_nx   = S_IDLE;
          cool_nx = '0;
        end else begin
          cool_nx = cool_q + 1'b1;
        end
      end
      default: begin
        st_nx    = S_IDLE;
        dwell_nx = '0;
        cool_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IDLE;
      dwell_q   <= '0;
      cool_q    <= '0;
      ign_q     <= '0;
      pulse_q   <= 1'b0;
      aligned_q <= 1'b0;
      delta_q   <= '0;
      delta_vld <= 1'b0;
    end else begin
      // The pulse self-clears on the following clk edge even without a strobe.
      pulse_q <= 1'b0;
      if (bus.clk_en) begin
        delta_q   <= delta_mag;
        delta_vld <= 1'b1;
        st        <= st_nx;
        dwell_q   <= dwell_nx;
        cool_q    <= cool_nx;
        ign_q     <= ign_nx;
        pulse_q   <= pulse_nx;
        aligned_q <= (st_nx == S_ALIGNED);
      end
    end
  end

  assign bus.state          = st;
  assign bus.aligned        = aligned_q;
  assign bus.ignition_pulse = pulse_q;
  assign bus.delta_abs      = delta_q;
  assign bus.dwell_count    = dwell_q;
  assign bus.ignition_count = ign_q;

endmodule

// File: tb/tb_sr_alignment_detector.sv
// Directed bench for sr_alignment_detector with short dwell/cooldown so every
// transition can be walked tick by tick against hand-computed values.
module tb_sr_alignment_detector;
  localparam int WIDTH = 18;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  sr_alignment_detector_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) ifc ();

  sr_alignment_detector #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .TOL_ENTER(4), .TOL_EXIT(8),
    .DWELL(4), .COOLDOWN(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk_en strobe; outputs are sampled 1 ns after the strobed edge.
  task automatic tick();
    @(negedge clk);
    ifc.clk_en = 1'b1;
    @(posedge clk);
    #1;
    ifc.clk_en = 1'b0;
  endtask

  task automatic set_in(input int sr, input int oi);
    ifc.omega_dt_sr  = WIDTH'(sr);
    ifc.omega_dt_int = WIDTH'(oi);
  endtask

  initial begin
    ifc.clk_en = 1'b0;
    ifc.enable = 1'b0;
    set_in(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(ifc.state), 0);
    chk("rst_delta", 32'(ifc.delta_abs), 0);
    chk("rst_dwell", 32'(ifc.dwell_count), 0);
    chk("rst_ign", 32'(ifc.ignition_count), 0);
    chk("rst_aligned", 32'(ifc.aligned), 0);

    // Ignition: delta 2, constant from tick 0
    ifc.enable = 1'b1;
    set_in(199, 201);
    tick();
    chk("ign_t0_delta", 32'(ifc.delta_abs), 2);
    chk("ign_t0_state", 32'(ifc.state), 0);
    tick();
    chk("ign_t1_state", 32'(ifc.state), 1);
    chk("ign_t1_dwell", 32'(ifc.dwell_count), 1);
    tick();
    chk("ign_t2_dwell", 32'(ifc.dwell_count), 2);
    tick();
    chk("ign_t3_state", 32'(ifc.state), 1);
    chk("ign_t3_dwell", 32'(ifc.dwell_count), 3);
    chk("ign_t3_pulse", 32'(ifc.ignition_pulse), 0);
    tick();
    chk("ign_t4_state", 32'(ifc.state), 2);
    chk("ign_t4_aligned", 32'(ifc.aligned), 1);
    chk("ign_t4_pulse", 32'(ifc.ignition_pulse), 1);
    chk("ign_t4_count", 32'(ifc.ignition_count), 1);
    chk("ign_t4_dwell", 32'(ifc.dwell_count), 4);
    @(posedge clk);
    #1;
    chk("ign_pulse_clr", 32'(ifc.ignition_pulse), 0);
    chk("ign_hold_state", 32'(ifc.state), 2);

    // Hysteresis: delta 7 holds, delta 9 exits into cooldown
    set_in(199, 206);
    tick();
    tick();
    chk("hys_d7_delta", 32'(ifc.delta_abs), 7);
    chk("hys_d7_state", 32'(ifc.state), 2);
    chk("hys_d7_aligned", 32'(ifc.aligned), 1);
    set_in(199, 208);
    tick();
    chk("hys_d9_lat", 32'(ifc.state), 2);
    set_in(199, 199);
    tick();
    chk("hys_d9_state", 32'(ifc.state), 3);
    chk("hys_d9_aligned", 32'(ifc.aligned), 0);
    chk("hys_d9_dwell", 32'(ifc.dwell_count), 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("cool_%0d", i), 32'(ifc.state), 3);
    end
    tick();
    chk("cool_end_state", 32'(ifc.state), 0);
    chk("cool_end_pulse", 32'(ifc.ignition_pulse), 0);
    tick();
    chk("cool_reentry", 32'(ifc.state), 1);
    chk("cool_re_dwell", 32'(ifc.dwell_count), 1);
    chk("cool_ign_cnt", 32'(ifc.ignition_count), 1);

    // Gating: no strobes with out-of-band inputs, then enable drop
    set_in(199, 250);
    repeat (50) @(posedge clk);
    #1;
    chk("gate_state", 32'(ifc.state), 1);
    chk("gate_dwell", 32'(ifc.dwell_count), 1);
    chk("gate_delta", 32'(ifc.delta_abs), 0);
    set_in(199, 199);
    ifc.enable = 1'b0;
    tick();
    chk("dis_state", 32'(ifc.state), 0);
    chk("dis_dwell", 32'(ifc.dwell_count), 0);

    // Broken dwell: flush an out-of-band sample, then in band for ticks 0-2
    set_in(199, 250);
    tick();
    chk("brk_pre_delta", 32'(ifc.delta_abs), 51);
    ifc.enable = 1'b1;
    set_in(199, 201);
    tick();
    chk("brk_t0_state", 32'(ifc.state), 0);
    tick();
    tick();
    chk("brk_t2_dwell", 32'(ifc.dwell_count), 2);
    set_in(199, 205);
    tick();
    chk("brk_t3_state", 32'(ifc.state), 1);
    chk("brk_t3_dwell", 32'(ifc.dwell_count), 3);
    chk("brk_t3_delta", 32'(ifc.delta_abs), 6);
    tick();
    chk("brk_t4_state", 32'(ifc.state), 0);
    chk("brk_t4_dwell", 32'(ifc.dwell_count), 0);
    chk("brk_t4_pulse", 32'(ifc.ignition_pulse), 0);
    chk("brk_ign_cnt", 32'(ifc.ignition_count), 1);

    // Extremes
    set_in(131071, -131072);
    tick();
    chk("ext_delta", 32'(ifc.delta_abs), 262143);
    tick();
    chk("ext_state", 32'(ifc.state), 0);
    set_in(-131072, 131071);
    tick();
    chk("ext_swap_delta", 32'(ifc.delta_abs), 262143);
    tick();
    chk("ext_swap_state", 32'(ifc.state), 0);

    // Asynchronous reset mid-dwell
    set_in(199, 201);
    tick();
    tick();
    chk("rst2_pre_state", 32'(ifc.state), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(ifc.state), 0);
    chk("arst_delta", 32'(ifc.delta_abs), 0);
    chk("arst_dwell", 32'(ifc.dwell_count), 0);
    chk("arst_ign", 32'(ifc.ignition_count), 0);
    chk("arst_aligned", 32'(ifc.aligned), 0);
    chk("arst_pulse", 32'(ifc.ignition_pulse), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
